// File: rtl/shift_rx_v_if.sv
// Bundles the serial line, its strobe and bit-order select with the
// received-word outputs of shift_rx_v.
interface shift_rx_v_if #(
  parameter int W = 4
) ();
  logic         en;
  logic         sin;
  logic         dir;
  logic [W-1:0] result;
  logic         valid;
  logic         perr;
  logic         ferr;
  logic         busy;

  modport master (
    output en, sin, dir,
    input  result, valid, perr, ferr, busy
  );

  modport slave (
    input  en, sin, dir,
    output result, valid, perr, ferr, busy
  );
endinterface

// File: rtl/shift_rx_v.sv
// Strobed serial frame receiver: start bit, W data bits (MSB or LSB first),
// optional even-parity bit, stop bit. Delivers the word with a one-cycle
// valid pulse, or a one-cycle framing-error pulse when the stop bit is low.
module shift_rx_v #(
  parameter int W      = 4,
  parameter bit PAR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  shift_rx_v_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    shreg;
  logic            dir_lat;
  logic            par_bit;
  logic            last_bit;

  logic [W-1:0]    result_p1;
  logic            valid_p1;
  logic            perr_p1;
  logic            ferr_p1;

  // Even parity over data plus received parity bit; never flags without parity.
  function automatic logic parity_err(input logic [W-1:0] d, input logic p);
    return PAR_EN ? ((^d) ^ p) : 1'b0;
  endfunction

  assign last_bit = (cnt == CW'(W - 1));

  // State register; everything else only moves on strobed edges.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; every transition is gated by the bit strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en && !bus.sin) state_nxt = DATA;
      DATA:    if (bus.en && last_bit) state_nxt = PAR_EN ? PARITY : STOP;
      PARITY:  if (bus.en)             state_nxt = STOP;
      STOP:    if (bus.en)             state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter and the registered result/flag stage.
  // Result and flags are registered, so they appear the cycle after the stop strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      shreg     <= '0;
      dir_lat   <= 1'b0;
      par_bit   <= 1'b0;
      result_p1 <= '0;
      valid_p1  <= 1'b0;
      perr_p1   <= 1'b0;
      ferr_p1   <= 1'b0;
    end else begin
      valid_p1 <= 1'b0;
      ferr_p1  <= 1'b0;
      if (bus.en) begin
        case (state)
          IDLE: begin
            if (!bus.sin) begin
              dir_lat <= bus.dir;
              cnt     <= '0;
            end
          end
          DATA: begin
            if (dir_lat) shreg <= {bus.sin, shreg[W-1:1]};
            else         shreg <= {shreg[W-2:0], bus.sin};
            if (!last_bit) cnt <= cnt + 1'b1;
          end
          PARITY: par_bit <= bus.sin;
          STOP: begin
            if (bus.sin) begin
              result_p1 <= shreg;
              valid_p1  <= 1'b1;
              perr_p1   <= parity_err(shreg, par_bit);
            end else begin
              ferr_p1   <= 1'b1;
              perr_p1   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.result = result_p1;
  assign bus.valid  = valid_p1;
  assign bus.perr   = perr_p1;
  assign bus.ferr   = ferr_p1;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_shift_rx_v.sv
// Self-checking bench for shift_rx_v (W=4, parity on). Frames are driven as
// 7-symbol sequences (start, 4 data, parity, stop); the expected outcome is
// queued at drive time and compared when valid or ferr pulses.
module tb_shift_rx_v;

  localparam int W = 4;

  typedef struct packed {
    logic         ferr;
    logic         perr;
    logic [W-1:0] result;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [W-1:0] last_result = '0;
  logic held_perr = 1'b0;

  shift_rx_v_if #(.W(W)) bus ();

  shift_rx_v #(.W(W), .PAR_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Single strobed symbol, inputs changed just after the active edge.
  task automatic pulse(input logic b);
    bus.en  = 1'b1;
    bus.sin = b;
    @(posedge clk); #1;
    bus.en  = 1'b0;
    bus.sin = 1'b1;
  endtask

  // seq[6] is sent first: start, d0..d3 (in line order), parity, stop.
  task automatic send_frame(input logic [6:0] seq, input logic d, input int gap, input logic flip);
    logic [W-1:0] exp_r;
    logic         good;
    exp_t         e;
    exp_r = '0;
    for (int k = 0; k < W; k++) begin
      if (d) exp_r[k]       = seq[5-k];
      else   exp_r[W-1-k]   = seq[5-k];
    end
    good = seq[0];
    if (good) begin
      e.ferr = 1'b0; e.perr = (^exp_r) ^ seq[1]; e.result = exp_r;
      last_result = exp_r;
    end else begin
      e.ferr = 1'b1; e.perr = 1'b0; e.result = last_result;
    end
    sb.push_back(e);
    bus.dir = d;
    for (int i = 6; i >= 0; i--) begin
      pulse(seq[i]);
      if (i == 6 && flip) bus.dir = ~d;
      if (i > 0) begin
        check("busy_in_frame", 32'(bus.busy), 32'd1);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          check("busy_gap", 32'(bus.busy), 32'd1);
        end
      end
    end
    check("busy_after_stop", 32'(bus.busy), 32'd0);
    check("pulse_after_stop", 32'({bus.valid, bus.ferr}), good ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    check("pulse_width", 32'({bus.valid, bus.ferr}), 32'd0);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      held_perr = 1'b0;
    end else if (bus.valid || bus.ferr) begin
      check("valid_ferr_excl", 32'(bus.valid & bus.ferr), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({bus.valid, bus.ferr}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", 32'(bus.result), 32'(e.result));
        check("sb_perr",   32'(bus.perr),   32'(e.perr));
        check("sb_ferr",   32'(bus.ferr),   32'(e.ferr));
        check("sb_valid",  32'(bus.valid),  32'(!e.ferr));
        held_perr = e.perr;
      end
    end else begin
      check("perr_held", 32'(bus.perr), 32'(held_perr));
    end
  end

  initial begin
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.sin = 1'b1;
    bus.dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({bus.result, bus.valid, bus.perr, bus.ferr, bus.busy}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Idle strobe with the line high must not start a frame.
    pulse(1'b1);
    check("idle_high_stays", 32'(bus.busy), 32'd0);

    send_frame(7'b0101001, 1'b0, 0, 1'b0);
    check("r030_result", 32'(bus.result), 32'hA);
    send_frame(7'b0101001, 1'b1, 0, 1'b0);
    check("r031_result", 32'(bus.result), 32'h5);
    send_frame(7'b0101011, 1'b0, 0, 1'b0);
    check("r032_result", 32'(bus.result), 32'hA);
    check("r032_perr", 32'(bus.perr), 32'd1);
    send_frame(7'b0101001, 1'b0, 0, 1'b0);
    send_frame(7'b0111100, 1'b0, 0, 1'b0);
    check("r033_result_held", 32'(bus.result), 32'hA);
    check("r033_perr_clear", 32'(bus.perr), 32'd0);

    // Mid-frame reset overrides a strobed start-level symbol.
    bus.dir = 1'b0;
    pulse(1'b0);
    pulse(1'b1);
    pulse(1'b0);
    rst     = 1'b1;
    bus.en  = 1'b1;
    bus.sin = 1'b0;
    @(posedge clk); #1;
    check("r034_reset_outs", 32'({bus.result, bus.valid, bus.perr, bus.ferr, bus.busy}), 32'd0);
    @(posedge clk); #1;
    bus.en  = 1'b0;
    bus.sin = 1'b1;
    rst     = 1'b0;
    last_result = '0;
    send_frame(7'b0101001, 1'b0, 0, 1'b0);
    check("r034_result", 32'(bus.result), 32'hA);

    send_frame(7'b0101001, 1'b0, 3, 1'b0);
    check("r035_result", 32'(bus.result), 32'hA);

    // dir flipped after the start bit must be ignored.
    send_frame(7'b0110001, 1'b0, 1, 1'b1);
    check("dir_flip_result", 32'(bus.result), 32'hC);

    for (int n = 0; n < 8; n++) begin
      logic [6:0] s;
      s = {1'b0, 4'($urandom), 1'($urandom), 1'($urandom)};
      send_frame(s, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_rx_v.md
SHIFT_RX_V -- requirements
Module: shift_rx_v

Interface
REQ-001 Parameter W, default 4, data bits per frame (legal range 2..8).
REQ-002 Parameter PAR_EN, default 1, 1 = even-parity bit present in frame, 0 = no parity bit.
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port en  input  1  bit strobe, line sampled only on rising edges where en=1.
REQ-006 Port sin  input  1  serial line, idles high.
REQ-007 Port dir  input  1  bit order, 0 = MSB first, 1 = LSB first; sampled with start bit.
REQ-008 Port result  output  W  last correctly framed data word.
REQ-009 Port valid  output  1  one-cycle pulse, result updated this cycle.
REQ-010 Port perr  output  1  parity error flag, qualifies valid.
REQ-011 Port ferr  output  1  one-cycle pulse, stop bit sampled low.
REQ-012 Port busy  output  1  high while a frame is in progress.

Function
REQ-013 FSM states SHALL be IDLE, DATA, PARITY, STOP; all transitions occur only on en=1 edges, except reset.
REQ-014 IDLE: en=1 and sin=0 -> DATA, latch dir, clear bit counter; en=1 and sin=1 -> stay IDLE.
REQ-015 DATA: each en=1 edge shifts sin into the shift register; dir=0 shifts left with sin into bit 0; dir=1 shifts right with sin into bit W-1.
REQ-016 DATA: after W data bits -> PARITY if PAR_EN=1, else -> STOP; bit counter width ceil(log2 W), no wrap past W-1.
REQ-017 PARITY: on en=1 capture sin as received parity bit -> STOP.
REQ-018 Even parity: perr = 1 when XOR of W data bits and received parity bit is 1; perr = 0 always when PAR_EN=0.
REQ-019 STOP, en=1, sin=1: result <= shift register, valid=1, perr per REQ-018, -> IDLE.
REQ-020 STOP, en=1, sin=0: ferr=1, valid=0, result held, perr=0, -> IDLE.
REQ-021 Latency: valid/ferr asserted in the cycle following the en=1 edge that samples the stop bit, for exactly one cycle.
REQ-022 valid, ferr SHALL never be high in the same cycle; perr held until next valid or ferr, then updated/cleared.
REQ-023 busy = 1 in DATA, PARITY, STOP; 0 in IDLE.
REQ-024 en=0 cycles inside a frame SHALL freeze all state; arbitrary gaps between strobes legal.
REQ-025 A start bit sampled in the same en edge that returns the FSM to IDLE is not detected; the next start needs a fresh en=1 edge in IDLE.
REQ-026 dir changes during a frame SHALL have no effect until the next start bit.

Reset
REQ-027 rst=1 at a rising edge -> IDLE, shift register 0, result 0, valid 0, perr 0, ferr 0, busy 0, bit counter 0.
REQ-028 rst SHALL override en and sin in the same cycle, including mid-frame; partial frame discarded, no valid or ferr pulse.
REQ-029 After rst deasserts, first start bit is accepted on the first en=1 edge with sin=0.

Verification
REQ-030 W=4, PAR_EN=1, dir=0, sin per strobe 0,1,0,1,0,0,1 -> result=4'b1010, valid pulse 1 cycle, perr=0, ferr=0.
REQ-031 Same sequence with dir=1 -> result=4'b0101, valid=1, perr=0.
REQ-032 dir=0, sin 0,1,0,1,0,1,1 (bad parity) -> result=4'b1010, valid=1, perr=1.
REQ-033 After REQ-030, frame 0,1,1,1,1,0,0 (stop low) -> ferr pulse, valid=0, result stays 4'b1010.
REQ-034 rst=1 after start + 2 data bits -> all outputs 0, busy=0; then the REQ-030 frame -> result=4'b1010, valid=1.
REQ-035 REQ-030 frame with 3 en=0 cycles between every strobe -> identical result, valid one cycle after stop strobe, busy continuous high from start to stop.
